// File: rtl/execute_stage.sv
// RV32 EX stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// PCSrcE/PCTargetE are combinational; everything headed for MEM is registered.
module execute_stage #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] RD1E,
  input  logic [WORD_SIZE-1:0] RD2E,
  input  logic [WORD_SIZE-1:0] PCE,
  input  logic [WORD_SIZE-1:0] PCPlus4E,
  input  logic [WORD_SIZE-1:0] ImmExtE,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 JumpE,
  input  logic                 BranchE,
  input  logic                 ALUSrcE,
  input  logic                 ByteAddressE,
  input  logic [1:0]           ResultSrcE,
  input  logic [2:0]           ALUControlE,
  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
  input  logic [WORD_SIZE-1:0] ResultW,
  input  logic                 StallM,
  input  logic                 FlushM,
  output logic                 PCSrcE,
  output logic [WORD_SIZE-1:0] PCTargetE,
  output logic [WORD_SIZE-1:0] ALUResultM,
  output logic [WORD_SIZE-1:0] WriteDataM,
  output logic [WORD_SIZE-1:0] PCPlus4M,
  output logic [4:0]           RdM,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 ByteAddressM,
  output logic [1:0]           ResultSrcM,
  output logic                 ResultSrcE0H
);

  typedef struct packed {
    logic [WORD_SIZE-1:0] alu_result;
    logic [WORD_SIZE-1:0] write_data;
    logic [WORD_SIZE-1:0] pc_plus4;
    logic [4:0]           rd;
    logic                 reg_write;
    logic                 mem_write;
    logic                 byte_address;
    logic [1:0]           result_src;
  } exmem_t;

  exmem_t exmem_d, exmem_q;

  logic [WORD_SIZE-1:0] src_a, write_data_e, src_b, alu_result_e;
  logic                 zero_e;

  // Forward-from-M always reads the register output, so a stalled M stage supplies its held value.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = exmem_q.alu_result;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = exmem_q.alu_result;
      default: write_data_e = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data_e;

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result_e = src_a + src_b;
      3'b001:  alu_result_e = src_a - src_b;
      3'b010:  alu_result_e = src_a & src_b;
      3'b011:  alu_result_e = src_a | src_b;
      3'b100:  alu_result_e = src_a ^ src_b;
      3'b101:  alu_result_e = {{(WORD_SIZE-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110:  alu_result_e = src_a << src_b[4:0];
      default: alu_result_e = src_a >> src_b[4:0];
    endcase
  end

  assign zero_e       = (alu_result_e == '0);
  assign PCTargetE    = PCE + ImmExtE;
  assign PCSrcE       = JumpE | (BranchE & zero_e);
  assign ResultSrcE0H = ResultSrcE[0];

  always_comb begin
    exmem_d = exmem_q;
    if (FlushM) begin
      exmem_d = '0;
    end else if (!StallM) begin
      exmem_d.alu_result   = alu_result_e;
      exmem_d.write_data   = write_data_e;
      exmem_d.pc_plus4     = PCPlus4E;
      exmem_d.rd           = RdE;
      exmem_d.reg_write    = RegWriteE;
      exmem_d.mem_write    = MemWriteE;
      exmem_d.byte_address = ByteAddressE;
      exmem_d.result_src   = ResultSrcE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exmem_q <= '0;
    else     exmem_q <= exmem_d;
  end

  assign ALUResultM   = exmem_q.alu_result;
  assign WriteDataM   = exmem_q.write_data;
  assign PCPlus4M     = exmem_q.pc_plus4;
  assign RdM          = exmem_q.rd;
  assign RegWriteM    = exmem_q.reg_write;
  assign MemWriteM    = exmem_q.mem_write;
  assign ByteAddressM = exmem_q.byte_address;
  assign ResultSrcM   = exmem_q.result_src;

endmodule

// File: tb/tb_execute_stage.sv
// Directed vector bench for execute_stage: table of single-cycle ops plus stall/flush/reset sequences.
module tb_execute_stage;

  logic        clk, rst;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ByteAddressE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic        StallM, FlushM;
  logic        PCSrcE, RegWriteM, MemWriteM, ByteAddressM, ResultSrcE0H;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;

  int total = 0;
  int bad   = 0;

  execute_stage #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ByteAddressE(ByteAddressE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ByteAddressM(ByteAddressM), .ResultSrcM(ResultSrcM), .ResultSrcE0H(ResultSrcE0H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, pc, imm;
    logic [2:0]  ctl;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] resw;
    logic        br, jmp;
    logic [4:0]  rd;
    logic        rw, mw, ba;
    logic [1:0]  rs;
    logic        e_pcsrc;
    logic [31:0] e_tgt, e_alu, e_wd;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RD1E = v.rd1; RD2E = v.rd2; PCE = v.pc; PCPlus4E = v.pc + 32'd4; ImmExtE = v.imm;
    ALUControlE = v.ctl; ALUSrcE = v.alusrc; ForwardAE = v.fa; ForwardBE = v.fb;
    ResultW = v.resw; BranchE = v.br; JumpE = v.jmp; RdE = v.rd; RegWriteE = v.rw;
    MemWriteE = v.mw; ByteAddressE = v.ba; ResultSrcE = v.rs;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".alu"}, ALUResultM, 32'd0);
    chk({nm, ".wd"},  WriteDataM, 32'd0);
    chk({nm, ".pc4"}, PCPlus4M, 32'd0);
    chk({nm, ".ctl"}, {20'd0, RdM, RegWriteM, MemWriteM, ByteAddressM, ResultSrcM}, 32'd0);
  endtask

  initial begin
    //          rd1            rd2            pc           imm            ctl     src   fa     fb     resw        br    jmp   rd     rw    mw    ba    rs     pcsrc tgt           alu           wd
    vecs[0]  = '{32'd5,        32'd3,        32'h0,       32'h0,        3'b001, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'd2,        32'd3};
    vecs[1]  = '{32'd8,        32'd8,        32'h0,       32'h0,        3'b000, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h10,       32'd8};
    vecs[2]  = '{32'd1,        32'h55,       32'h0,       32'h4,        3'b000, 1'b1, 2'b10, 2'b01, 32'hAA,    1'b0, 1'b0, 5'd6,  1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h4,        32'h14,       32'hAA};
    vecs[3]  = '{32'hDEAD,     32'd2,        32'h0,       32'h0,        3'b000, 1'b0, 2'b01, 2'b00, 32'h30,    1'b0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0,        32'h32,       32'd2};
    vecs[4]  = '{32'd7,        32'd1,        32'h40,      32'h8,        3'b000, 1'b0, 2'b11, 2'b11, 32'h99,    1'b0, 1'b0, 5'd2,  1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h48,       32'd8,        32'd1};
    vecs[5]  = '{32'hFFFFFFFF, 32'd1,        32'h0,       32'h0,        3'b101, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'd1,        32'd1};
    vecs[6]  = '{32'd1,        32'hFFFFFFFF, 32'h0,       32'h0,        3'b101, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'd0,        32'hFFFFFFFF};
    vecs[7]  = '{32'h80000000, 32'd31,       32'h0,       32'h0,        3'b111, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'd1,        32'd31};
    vecs[8]  = '{32'd3,        32'h77,       32'h0,       32'h21,       3'b110, 1'b1, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h21,       32'd6,        32'h77};
    vecs[9]  = '{32'hFFFFFFFF, 32'd1,        32'h0,       32'h0,        3'b000, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'd0,        32'd1};
    vecs[10] = '{32'hF0F0,     32'hFF00,     32'h0,       32'h0,        3'b010, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'hF000,     32'hFF00};
    vecs[11] = '{32'hF0F0,     32'h0F00,     32'h0,       32'h0,        3'b011, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'hFFF0,     32'h0F00};
    vecs[12] = '{32'hFF,       32'h0F,       32'h0,       32'h0,        3'b100, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'hF0,       32'h0F};
    vecs[13] = '{32'd9,        32'd9,        32'h100,     32'hFFFFFFF8, 3'b001, 1'b0, 2'b00, 2'b00, 32'h0,     1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hF8,       32'd0,        32'd9};
    vecs[14] = '{32'd9,        32'd8,        32'h100,     32'hFFFFFFF8, 3'b001, 1'b0, 2'b00, 2'b00, 32'h0,     1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'hF8,       32'd1,        32'd8};
    vecs[15] = '{32'd1,        32'd2,        32'h200,     32'h10,       3'b000, 1'b0, 2'b00, 2'b00, 32'h0,     1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 32'h210,      32'd3,        32'd2};
    vecs[16] = '{32'd1,        32'd5,        32'h0,       32'h0,        3'b110, 1'b0, 2'b00, 2'b10, 32'h0,     1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'd8,        32'd3};

    // Reset state with all inputs quiet
    rst = 1'b1; StallM = 1'b0; FlushM = 1'b0;
    drive('{default: '0});
    #1;
    chk_all_zero("reset");
    chk("reset.pcsrc", {31'd0, PCSrcE}, 32'd0);
    chk("reset.tgt", PCTargetE, 32'd0);
    #2 rst = 1'b0;
    tick;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.pcsrc", i), {31'd0, PCSrcE}, {31'd0, vecs[i].e_pcsrc});
      chk($sformatf("v%0d.tgt", i), PCTargetE, vecs[i].e_tgt);
      chk($sformatf("v%0d.rs0h", i), {31'd0, ResultSrcE0H}, {31'd0, vecs[i].rs[0]});
      tick;
      chk($sformatf("v%0d.alu", i), ALUResultM, vecs[i].e_alu);
      chk($sformatf("v%0d.wd", i), WriteDataM, vecs[i].e_wd);
      chk($sformatf("v%0d.pc4", i), PCPlus4M, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d.ctl", i), {20'd0, RdM, RegWriteM, MemWriteM, ByteAddressM, ResultSrcM},
          {20'd0, vecs[i].rd, vecs[i].rw, vecs[i].mw, vecs[i].ba, vecs[i].rs});
    end

    // Stall two edges; forward-from-M reads the held ALUResultM (8): 8 - 8 = 0 -> branch taken
    drive('{rd1: 32'd0, rd2: 32'd8, pc: 32'h0, imm: 32'h0, ctl: 3'b001, fa: 2'b10, br: 1'b1,
            rd: 5'd3, rw: 1'b1, default: '0});
    StallM = 1'b1;
    #1;
    chk("stall.fwd_pcsrc", {31'd0, PCSrcE}, 32'd1);
    tick;
    chk("stall1.alu", ALUResultM, 32'd8);
    chk("stall1.fwd_pcsrc", {31'd0, PCSrcE}, 32'd1);
    tick;
    chk("stall2.alu", ALUResultM, 32'd8);
    chk("stall2.wd", WriteDataM, 32'd3);
    chk("stall2.rd", {27'd0, RdM}, 32'd9);
    StallM = 1'b0;
    tick;
    chk("unstall.alu", ALUResultM, 32'd0);
    chk("unstall.wd", WriteDataM, 32'd8);
    chk("unstall.rd", {27'd0, RdM}, 32'd3);

    // Load something nonzero, then flush and stall together: flush wins
    drive('{rd1: 32'd4, rd2: 32'd4, pc: 32'h20, rd: 5'd12, rw: 1'b1, mw: 1'b1, ba: 1'b1,
            rs: 2'b01, default: '0});
    tick;
    chk("pre_flush.alu", ALUResultM, 32'd8);
    FlushM = 1'b1; StallM = 1'b1;
    tick;
    chk_all_zero("flush_stall");
    FlushM = 1'b0; StallM = 1'b0;
    tick;
    chk("reload.alu", ALUResultM, 32'd8);
    chk("reload.ctl", {27'd0, RegWriteM, MemWriteM, ByteAddressM, ResultSrcM}, 32'b11101);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    drive('{default: '0});
    #1;
    chk("async_rst.pcsrc", {31'd0, PCSrcE}, 32'd0);
    rst = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RV32 pipeline. It sits directly downstream of the decode stage and consumes that stage's ID/EX outputs.
- Resolves operand forwarding, performs the ALU operation, computes branch/jump target and redirect, and holds the EX/MEM pipeline register feeding the memory stage.

Parameters:
WORD_SIZE, 32, datapath width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
RD1E, RD2E  input  WORD_SIZE  register operands from ID/EX
PCE, PCPlus4E, ImmExtE  input  WORD_SIZE  PC, PC+4, extended immediate
RdE  input  5  destination register
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ByteAddressE  input  1  control from ID/EX
ResultSrcE  input  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  input  3  ALU operation code
ForwardAE, ForwardBE  input  2  forwarding select from hazard unit
ResultW  input  WORD_SIZE  writeback result, forwarding source
StallM, FlushM  input  1  EX/MEM register hold / bubble
PCSrcE  output  1  redirect fetch (combinational)
PCTargetE  output  WORD_SIZE  branch/jump target (combinational)
ALUResultM, WriteDataM, PCPlus4M  output  WORD_SIZE  EX/MEM data
RdM  output  5  EX/MEM destination
RegWriteM, MemWriteM, ByteAddressM  output  1  EX/MEM control
ResultSrcM  output  2  EX/MEM result select
ResultSrcE0H  output  1  ResultSrcE[0] to hazard unit for load-use detection

Behaviour:
- Clock and reset: clk is the clock; rst is asynchronous, active-high.
- Forwarding for SrcAE, selected by ForwardAE:
  - 00: RD1E
  - 01: ResultW
  - 10: the registered ALUResultM
  - 11: treated as 00
- Forwarding for the B operand (ForwardBE) uses the same encoding on RD2E.
- Operand select:
  - WriteDataE = forwarded B.
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, combinational, with results wrapped modulo 2^WORD_SIZE:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed; result 1 or 0, zero-extended)
  - 110 sll by SrcBE[4:0]
  - 111 srl (logical) by SrcBE[4:0]
- ZeroE = (ALUResultE == 0).
- Branch resolution:
  - PCTargetE = PCE + ImmExtE, wrapping.
  - PCSrcE = JumpE | (BranchE & ZeroE).
  - Both are same-cycle combinational and are not affected by StallM or FlushM.
- EX/MEM register, one rising-edge latency. Priority is rst, then FlushM, then StallM, then load:
  - rst: asynchronous clear of every registered output to 0.
  - FlushM (synchronous): clears all fields to 0, which is a bubble because RegWriteM=0 and MemWriteM=0.
  - StallM: holds all fields.
  - Otherwise, loads ALUResultE, WriteDataE, PCPlus4E, RdE, RegWriteE, MemWriteE, ByteAddressE and ResultSrcE.
- Reset values: all registered outputs are 0. PCSrcE and PCTargetE follow their inputs, so with decode also in reset PCSrcE=0 and PCTargetE=0.
- Simultaneous FlushM and StallM: flush wins.
- Reset mid-operation: the register clears immediately, without waiting for a clock edge.
- Forward-from-M while StallM=1: the source is the held ALUResultM value.
- Control bits pass through unmodified; this block does no decoding.

Test Plan:
- rst pulse with clk idle -> all M outputs 0 immediately; PCSrcE=0 once JumpE=BranchE=0.
- RD1E=5, RD2E=3, ALUControlE=001, ALUSrcE=0, Forward=00, RdE=7, RegWriteE=1 -> after 1 edge ALUResultM=2, WriteDataM=3, RdM=7, RegWriteM=1.
- Back-to-back dependency: cycle 1 add gives ALUResultM=0x10; cycle 2 ForwardAE=10, ImmExtE=4, ALUSrcE=1, ALUControlE=000 -> ALUResultM=0x14. ForwardBE=01 with ResultW=0xAA -> WriteDataM=0xAA.
- ALU corner cases:
  - slt with 0xFFFFFFFF vs 1 -> 1.
  - srl 0x80000000 by 31 -> 1.
  - sll by SrcBE=0x21 -> shift by 1.
  - add 0xFFFFFFFF+1 -> 0.
- Branch: BranchE=1, RD1E=RD2E=9, sub, PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCSrcE=1 and PCTargetE=0xF8 in the same cycle. With RD2E=8 -> PCSrcE=0. JumpE=1 -> PCSrcE=1 regardless of the ALU.
- Register controls:
  - StallM=1 for 2 edges -> outputs hold.
  - FlushM=1 with StallM=1 -> all M outputs 0 after the edge.
  - rst asserted between edges -> immediate clear.
